// File: rtl/sine_pwm_dac_pkg.sv
// Shared constants and state encoding for the sine PWM DAC block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sine_pwm_dac_pkg;

    // Default sample / PWM counter width; PWM period is 2**PWM_WIDTH clocks.
    localparam int PWM_WIDTH = 8;
    // Default amplitude control width; gain is (amp+1)/2**AMP_WIDTH.
    localparam int AMP_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sine_pwm_dac_sample_scaler.sv
// Scales an unsigned sample by (amp+1)/2**AMP_W, truncating toward zero.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is only consumed when the parent loads a sample.
module sample_scaler
    import sine_pwm_dac_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int AMP_W = AMP_WIDTH
) (
    input  logic [WIDTH-1:0] sample_i,
    input  logic [AMP_W-1:0] amp_i,
    output logic [WIDTH-1:0] scaled_o
);

    // amp+1 needs one extra bit so that amp=all-ones yields a gain of exactly 1.0.
    logic [AMP_W:0]         gain;
    // (2**WIDTH-1) * 2**AMP_W < 2**(WIDTH+AMP_W), so this width holds the full product.
    logic [WIDTH+AMP_W-1:0] sample_ext;
    logic [WIDTH+AMP_W-1:0] gain_ext;
    logic [WIDTH+AMP_W-1:0] product;

    assign gain       = {1'b0, amp_i} + {{AMP_W{1'b0}}, 1'b1};
    assign sample_ext = {{AMP_W{1'b0}}, sample_i};
    assign gain_ext   = {{(WIDTH-1){1'b0}}, gain};
    assign product    = sample_ext * gain_ext;
    // Keep the upper WIDTH bits of the product; the result never exceeds 2**WIDTH-1.
    assign scaled_o   = WIDTH'(product >> AMP_W);

endmodule

// File: rtl/sine_pwm_dac.sv
// Converts scaled sine samples into a single-bit PWM stream for an RC DAC.
// Latency: a sample is loaded on its sample_req edge and drives pwm_out from the next cycle.
// Backpressure: none from downstream; sample_req pulses once per period to pull the next upstream sample.
module sine_pwm_dac
    import sine_pwm_dac_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int AMP_W = AMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [AMP_W-1:0] amp,
    input  logic [WIDTH-1:0] sample_in,
    output logic             pwm_out,
    output logic             sample_req,
    output logic             period_done,
    output logic             busy,
    output logic [WIDTH-1:0] duty_q
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_d;
    logic [WIDTH-1:0] scaled;
    logic             cnt_last;

    sample_scaler #(
        .WIDTH (WIDTH),
        .AMP_W (AMP_W)
    ) u_scaler (
        .sample_i (sample_in),
        .amp_i    (amp),
        .scaled_o (scaled)
    );

    assign cnt_last = (cnt_q == {WIDTH{1'b1}});

    // Output decodes are built only from registered state/cnt plus the level-sensitive en,
    // so they are settled well before the sampling edge.
    assign period_done = (state_q == ST_RUN) && cnt_last;
    assign sample_req  = (state_q == ST_LOAD) || (period_done && en);
    assign busy        = (state_q != ST_IDLE);
    assign pwm_out     = (state_q == ST_RUN) && (cnt_q < duty_q);

    // Next-state logic: load on entry and on each enabled period boundary; a period
    // always runs to completion before honouring a dropped en.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                duty_d  = scaled;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Natural wrap from all-ones to zero gives a gapless 2**WIDTH period.
                cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
                if (cnt_last) begin
                    if (en) begin
                        duty_d = scaled;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and duty registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
        end
    end

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Directed bench for sine_pwm_dac with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; sample_req is observed only.
module tb_sine_pwm_dac;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] amp;
    logic [7:0] sample_in;
    logic       pwm_out;
    logic       sample_req;
    logic       period_done;
    logic       busy;
    logic [7:0] duty_q;

    int checks;
    int failures;

    sine_pwm_dac #(
        .WIDTH (8),
        .AMP_W (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .amp         (amp),
        .sample_in   (sample_in),
        .pwm_out     (pwm_out),
        .sample_req  (sample_req),
        .period_done (period_done),
        .busy        (busy),
        .duty_q      (duty_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Observes one full period starting at cnt=0 with en held high; leaves the DUT at
    // cnt=0 of the following period.
    task automatic measure(input string tag, input int exp_high);
        int highs, first_low, pd_cnt, pd_idx, req_cnt, req_idx, busy_cnt;
        highs = 0; first_low = -1; pd_cnt = 0; pd_idx = -1;
        req_cnt = 0; req_idx = -1; busy_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_out === 1'b1) highs++;
            else if (first_low < 0) first_low = i;
            if (period_done === 1'b1) begin pd_cnt++; pd_idx = i; end
            if (sample_req === 1'b1) begin req_cnt++; req_idx = i; end
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        if (first_low < 0) first_low = 256;
        chk({tag, "_highs"}, highs, exp_high);
        chk({tag, "_first_low"}, first_low, exp_high);
        chk({tag, "_pd_cnt"}, pd_cnt, 1);
        chk({tag, "_pd_idx"}, pd_idx, 255);
        chk({tag, "_req_cnt"}, req_cnt, 1);
        chk({tag, "_req_idx"}, req_idx, 255);
        chk({tag, "_busy"}, busy_cnt, 256);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0; en = 1'b0; amp = 3'd0; sample_in = 8'd0;

        // Reset state
        ticks(3);
        chk("rst_busy", busy, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_req", sample_req, 0);
        chk("rst_pd", period_done, 0);
        chk("rst_duty", duty_q, 0);

        // Test 1: 128 at full gain
        rst = 1'b1; en = 1'b1; sample_in = 8'd128; amp = 3'd7;
        chk("idle_req", sample_req, 0);
        tick();
        chk("load_req", sample_req, 1);
        chk("load_busy", busy, 1);
        chk("load_pwm", pwm_out, 0);
        tick();
        chk("t1_duty", duty_q, 128);
        // Next sample is presented early; it must only be taken at the boundary.
        sample_in = 8'd200; amp = 3'd3;
        chk("t1_duty_hold", duty_q, 128);
        measure("t1", 128);

        // Test 2: 200 * 4 / 8 = 100, then 200 * 1 / 8 = 25
        chk("t2_duty", duty_q, 100);
        amp = 3'd0;
        measure("t2a", 100);
        chk("t2b_duty", duty_q, 25);
        sample_in = 8'd0; amp = 3'd7;
        measure("t2b", 25);

        // Test 3: zero and maximum duty
        chk("t3_zero_duty", duty_q, 0);
        sample_in = 8'd255; amp = 3'd7;
        measure("t3_zero", 0);
        chk("t3_max_duty", duty_q, 255);
        measure("t3_max", 255);

        // Test 6: mid-period change of amp/sample takes effect only at the boundary
        ticks(10);
        amp = 3'd1; sample_in = 8'd80;       // 80 * 2 / 8 = 20
        tick();
        chk("t6_mid_duty", duty_q, 255);
        ticks(244);                           // now at cnt=255
        chk("t6_end_duty", duty_q, 255);
        chk("t6_end_pd", period_done, 1);
        chk("t6_end_req", sample_req, 1);
        tick();
        chk("t6_new_duty", duty_q, 20);
        chk("t6_new_pwm", pwm_out, 1);

        // Test 4: en dropped at cnt=50, period completes, then IDLE
        ticks(50);
        en = 1'b0;
        chk("t4_mid_busy", busy, 1);
        ticks(205);                           // now at cnt=255
        chk("t4_end_pd", period_done, 1);
        chk("t4_end_req", sample_req, 0);
        chk("t4_end_busy", busy, 1);
        tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_pwm", pwm_out, 0);
        chk("t4_idle_duty", duty_q, 20);
        ticks(3);
        chk("t4_idle_stay", busy, 0);
        en = 1'b1; sample_in = 8'd128; amp = 3'd7;
        tick();
        chk("t4_load_req", sample_req, 1);
        chk("t4_load_pwm", pwm_out, 0);
        tick();
        chk("t4_run_duty", duty_q, 128);
        chk("t4_run_pwm", pwm_out, 1);

        // Test 5: reset in the middle of a high pulse
        ticks(100);
        chk("t5_pre_pwm", pwm_out, 1);
        rst = 1'b0;
        tick();
        chk("t5_rst_pwm", pwm_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_duty", duty_q, 0);
        chk("t5_rst_req", sample_req, 0);
        chk("t5_rst_pd", period_done, 0);
        rst = 1'b1;
        chk("t5_idle_pwm", pwm_out, 0);
        tick();
        chk("t5_load_req", sample_req, 1);
        chk("t5_load_pwm", pwm_out, 0);
        tick();
        chk("t5_run_duty", duty_q, 128);
        measure("t5", 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
